lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencer between the EX stage and the data-memory bus. Accepts one decoded memory operation at a time (load/store enable, load funct3, one-hot store length), issues an aligned 64-bit bus request with byte mask, waits for the response, and returns sign/zero-extended load data to writeback. While an operation is in flight it holds the pipeline with `stall`.

## Interface
Parameters:
- `XLEN`, 64, data and address width (RV64).

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `ex_valid`  in  1  EX presents an instruction
- `ex_ready`  out  1  LSU can accept (state IDLE)
- `load_en`  in  1  decoded load
- `store_en`  in  1  decoded store
- `load_opcode`  in  3  load funct3
- `store_len`  in  4  one-hot bytes: 0001=1, 0010=2, 0100=4, 1000=8
- `addr`  in  XLEN  effective address (ALU sum)
- `wdata`  in  XLEN  store data (rs2)
- `mem_req_valid`  out  1  bus request valid
- `mem_req_ready`  in  1  bus accepts request
- `mem_req_addr`  out  XLEN  `{addr[XLEN-1:3],3'b0}`
- `mem_req_wen`  out  1  1=store
- `mem_req_wmask`  out  8  byte-enable
- `mem_req_wdata`  out  XLEN  lane-shifted store data
- `mem_resp_valid`  in  1  bus response (read data or store ack)
- `mem_resp_rdata`  in  XLEN  read data, full aligned doubleword
- `wb_valid`  out  1  result ready for writeback
- `wb_ready`  in  1  writeback consumes
- `wb_data`  out  XLEN  load result; 0 for stores
- `stall`  out  1  pipeline hold, = state != IDLE
- `misalign`  out  1  qualifies `wb_valid`: access faulted

## Operation
- FSM: IDLE, REQ, RESP, DONE.
- IDLE: `ex_ready`=1. `ex_valid & (load_en|store_en)` → latch op, addr, wdata; → REQ. Other instructions ignored. Both enables set → load wins.
- REQ: `mem_req_valid`=1, request fields stable from latched registers. `mem_req_ready` → RESP.
- RESP: wait `mem_resp_valid`; capture rdata → DONE. `mem_resp_valid` outside RESP is ignored.
- DONE: `wb_valid`=1, `wb_data` stable. `wb_ready` → IDLE.
- Store lanes: mask base 0x01/0x03/0x0F/0xFF from `store_len`; `wmask = base << addr[2:0]` truncated to 8 bits; `wdata << (addr[2:0]*8)` truncated to XLEN.
- Load: `rdata >> (addr[2:0]*8)`, then by funct3: 000 LB sext8, 001 LH sext16, 010 LW sext32, 011 LD, 100 LBU, 101 LHU, 110 LWU zext, 111 reserved → 0.
- Reset: `rst_n`=0 at any edge → IDLE; in-flight op dropped. All registered outputs and latches reset to 0. `ex_ready`=1 and all other outputs 0 after reset.

## Timing
- Accept at edge 0. REQ in cycle 1. With `mem_req_ready`=1 in cycle 1 and `mem_resp_valid`=1 in cycle 2, `wb_valid` is asserted in cycle 3. Minimum 3 cycles from accept to result, plus one cycle to return to IDLE.
- A back-to-back op can be accepted in the cycle after the `wb_ready` handshake.
- `stall` is registered-state derived and rises in the cycle after accept.
- All outputs are registered or decoded from state; there is no combinational path from `mem_resp_*` to `wb_*`.

## Configuration
- `LSU_MISALIGN_CHK_EN` defined:
  - An access is misaligned when `addr` is not a multiple of its size. For loads the size comes from funct3[1:0]; for stores it comes from `store_len`.
  - A misaligned op skips REQ/RESP and goes IDLE→DONE with `misalign`=1 and `wb_data`=0. No bus traffic is generated.
- Undefined:
  - `misalign` is tied 0.
  - Misaligned accesses are issued as-is. Bytes beyond the doubleword are dropped from the mask, and loads return the truncated shifted data.

## Structure
- `lsu_pkg`:
  - FSM state enum.
  - funct3 load constants (LB…LWU).
  - Function mapping `store_len` / funct3 to a byte mask and size.
- Sub-module `lsu_load_align`: combinational shift plus sign/zero-extend of `mem_resp_rdata`, instantiated once.

## Test plan
- LD at 0x1000, resp rdata 0x8877665544332211, zero-wait bus → `wb_valid` cycle 3, `wb_data`=0x8877665544332211, mask unused, `mem_req_wen`=0.
- LB at 0x1007, rdata 0x80xx_xxxx_xxxx_xxxx → `wb_data`=0xFFFFFFFFFFFFFF80. LBU at the same address → 0x80.
- SH at 0x2002, wdata 0xABCD, `store_len`=0010 → `mem_req_addr`=0x2000, wmask=0x0C, wdata=0xABCD0000. `wb_data`=0 after ack.
- `mem_req_ready` held low 4 cycles, resp delayed 3 cycles, `wb_ready` low 2 cycles → request fields and `wb_data` stable throughout; `stall`=1 until the DONE handshake.
- `rst_n` low for one edge while in RESP → IDLE, `mem_req_valid`=0, `wb_valid`=0; a late `mem_resp_valid` is ignored.
- With `LSU_MISALIGN_CHK_EN`, LW at 0x3002 → no `mem_req_valid`; `wb_valid` with `misalign`=1 and `wb_data`=0 one cycle after accept. Without the macro, the same LW issues wmask-free read at 0x3000 and `misalign`=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_pkg: shared types, load funct3 codes and byte-mask helpers.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_ld  = 3'b011;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;
    localparam logic [2:0] c_f3_lwu = 3'b110;

    // Unaligned byte mask for a one-hot store length; illegal encodings write nothing.
    function automatic logic [7:0] store_len_to_mask(input logic [3:0] len);
        logic [7:0] m;
        case (len)
            4'b0001: m = 8'h01;
            4'b0010: m = 8'h03;
            4'b0100: m = 8'h0F;
            4'b1000: m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] funct3_to_mask(input logic [2:0] f3);
        logic [7:0] m;
        case (f3[1:0])
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Access size minus one, used as the alignment mask on addr[2:0].
    function automatic logic [2:0] mask_to_align(input logic [7:0] base);
        logic [2:0] a;
        case (base)
            8'h03:   a = 3'd1;
            8'h0F:   a = 3'd3;
            8'hFF:   a = 3'd7;
            default: a = 3'd0;
        endcase
        return a;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// +----------------------------------------------------------------------+
// | lsu_load_align: lane shift and sign/zero extension of load data.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = '0;
        case (funct3)
            c_f3_lb:  data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            c_f3_lh:  data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            c_f3_lw:  data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            c_f3_ld:  data = w_shifted;
            c_f3_lbu: data = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            c_f3_lhu: data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            c_f3_lwu: data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            default:  data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// +----------------------------------------------------------------------+
// | lsu_ctrl: single-outstanding load/store sequencer, EX to data bus.   |
// | Optional misalignment trap: LSU_MISALIGN_CHK_EN.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            load_en,
    input  logic            store_en,
    input  logic [2:0]      load_opcode,
    input  logic [3:0]      store_len,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_wen,
    output logic [7:0]      mem_req_wmask,
    output logic [XLEN-1:0] mem_req_wdata,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            misalign
);

    lsu_state_t      r_state;
    logic            r_is_load;
    logic [2:0]      r_funct3;
    logic [3:0]      r_len;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_wb_data;

    logic            w_accept;
    logic            w_req;
    logic            w_req_store;
    logic [7:0]      w_store_mask;
    logic [XLEN-1:0] w_load_data;

    assign w_accept = ex_valid & (load_en | store_en);

    lsu_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata  (mem_resp_rdata),
        .offset (r_addr[2:0]),
        .funct3 (r_funct3),
        .data   (w_load_data)
    );

`ifdef LSU_MISALIGN_CHK_EN
    logic       r_misalign;
    logic [7:0] w_acc_base;
    logic       w_misaligned;

    // Load wins when both enables are set, so its size governs the check.
    assign w_acc_base   = load_en ? funct3_to_mask(load_opcode) : store_len_to_mask(store_len);
    assign w_misaligned = (addr[2:0] & mask_to_align(w_acc_base)) != 3'd0;
    assign misalign     = r_misalign;
`else
    assign misalign     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_is_load <= 1'b0;
            r_funct3  <= 3'd0;
            r_len     <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wb_data <= '0;
`ifdef LSU_MISALIGN_CHK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_is_load <= load_en;
                        r_funct3  <= load_opcode;
                        r_len     <= store_len;
                        r_addr    <= addr;
                        r_wdata   <= wdata;
                        r_wb_data <= '0;
`ifdef LSU_MISALIGN_CHK_EN
                        r_misalign <= w_misaligned;
                        r_state    <= w_misaligned ? ST_DONE : ST_REQ;
`else
                        r_state   <= ST_REQ;
`endif
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_resp_valid) begin
                        r_wb_data <= r_is_load ? w_load_data : '0;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (wb_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Request fields are decoded from latched operands and held at zero outside REQ.
    assign w_req        = (r_state == ST_REQ);
    assign w_req_store  = w_req & ~r_is_load;
    assign w_store_mask = store_len_to_mask(r_len) << r_addr[2:0];

    assign ex_ready      = (r_state == ST_IDLE);
    assign stall         = (r_state != ST_IDLE);
    assign mem_req_valid = w_req;
    assign mem_req_addr  = w_req ? {r_addr[XLEN-1:3], 3'b000} : '0;
    assign mem_req_wen   = w_req_store;
    assign mem_req_wmask = w_req_store ? w_store_mask : 8'h00;
    assign mem_req_wdata = w_req_store ? (r_wdata << {r_addr[2:0], 3'b000}) : '0;
    assign wb_valid      = (r_state == ST_DONE);
    assign wb_data       = r_wb_data;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_lsu_ctrl: directed self-checking bench for lsu_ctrl.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        load_en;
    logic        store_en;
    logic [2:0]  load_opcode;
    logic [3:0]  store_len;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [7:0]  mem_req_wmask;
    logic [63:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_data;
    logic        stall;
    logic        misalign;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.XLEN(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .load_en        (load_en),
        .store_en       (store_en),
        .load_opcode    (load_opcode),
        .store_len      (store_len),
        .addr           (addr),
        .wdata          (wdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wmask  (mem_req_wmask),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_data        (wb_data),
        .stall          (stall),
        .misalign       (misalign)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [3:0] len, input logic [63:0] a, input logic [63:0] wd);
        ex_valid = 1'b1; load_en = ld; store_en = st;
        load_opcode = f3; store_len = len; addr = a; wdata = wd;
        tick();
        ex_valid = 1'b0; load_en = 1'b0; store_en = 1'b0;
        addr = 64'hDEAD_BEEF_DEAD_BEEF; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    // Zero-wait operation: accept, REQ in cycle 1, resp in cycle 2, wb in cycle 3.
    task automatic do_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [3:0] len, input logic [63:0] a, input logic [63:0] wd,
                         input logic [63:0] rd, input logic [63:0] e_addr, input logic [7:0] e_mask,
                         input logic [63:0] e_wdata, input logic e_wen, input logic [63:0] e_wb);
        mem_req_ready = 1'b1;
        present(ld, st, f3, len, a, wd);
        check({tag, "_req_valid"}, mem_req_valid, 1);
        check({tag, "_stall"}, stall, 1);
        check({tag, "_req_addr"}, mem_req_addr, e_addr);
        check({tag, "_wen"}, mem_req_wen, e_wen);
        check({tag, "_wmask"}, mem_req_wmask, e_mask);
        check({tag, "_wdata"}, mem_req_wdata, e_wdata);
        tick();
        mem_req_ready = 1'b0;
        check({tag, "_resp_wait"}, mem_req_valid, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = rd;
        tick();
        mem_resp_valid = 1'b0; mem_resp_rdata = 64'h0;
        check({tag, "_wb_valid"}, wb_valid, 1);
        check({tag, "_wb_data"}, wb_data, e_wb);
        check({tag, "_misalign"}, misalign, 0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check({tag, "_idle"}, ex_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; load_en = 1'b0; store_en = 1'b0;
        load_opcode = 3'd0; store_len = 4'd0; addr = 64'h0; wdata = 64'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'h0; wb_ready = 1'b0;
        repeat (2) tick();
        check("rst_ex_ready", ex_ready, 1);
        check("rst_stall", stall, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_req_addr", mem_req_addr, 0);
        check("rst_misalign", misalign, 0);
        rst_n = 1'b1;
        tick();

        // ex_valid without a memory op is ignored
        present(1'b0, 1'b0, 3'd3, 4'd0, 64'h1000, 64'h0);
        check("nop_ready", ex_ready, 1);
        check("nop_req", mem_req_valid, 0);

        do_op("ld",  1, 0, 3'b011, 4'b0000, 64'h1000, 64'h0, 64'h8877665544332211,
              64'h1000, 8'h00, 64'h0, 0, 64'h8877665544332211);
        do_op("lb",  1, 0, 3'b000, 4'b0000, 64'h1007, 64'h0, 64'h8011223344556677,
              64'h1000, 8'h00, 64'h0, 0, 64'hFFFFFFFFFFFFFF80);
        do_op("lbu", 1, 0, 3'b100, 4'b0000, 64'h1007, 64'h0, 64'h8011223344556677,
              64'h1000, 8'h00, 64'h0, 0, 64'h0000000000000080);
        do_op("lh",  1, 0, 3'b001, 4'b0000, 64'h1006, 64'h0, 64'h8011223344556677,
              64'h1000, 8'h00, 64'h0, 0, 64'hFFFFFFFFFFFF8011);
        do_op("lhu", 1, 0, 3'b101, 4'b0000, 64'h1002, 64'h0, 64'h8011223344556677,
              64'h1000, 8'h00, 64'h0, 0, 64'h0000000000004455);
        do_op("lw",  1, 0, 3'b010, 4'b0000, 64'h1004, 64'h0, 64'h8011223344556677,
              64'h1000, 8'h00, 64'h0, 0, 64'hFFFFFFFF80112233);
        do_op("lwu", 1, 0, 3'b110, 4'b0000, 64'h1004, 64'h0, 64'h8011223344556677,
              64'h1000, 8'h00, 64'h0, 0, 64'h0000000080112233);
        do_op("lrsv", 1, 0, 3'b111, 4'b0000, 64'h1000, 64'h0, 64'h8011223344556677,
              64'h1000, 8'h00, 64'h0, 0, 64'h0);
        do_op("both", 1, 1, 3'b011, 4'b1000, 64'h1008, 64'h1234, 64'h0123456789ABCDEF,
              64'h1008, 8'h00, 64'h0, 0, 64'h0123456789ABCDEF);
        do_op("sh",  0, 1, 3'b000, 4'b0010, 64'h2002, 64'hABCD, 64'hDEADDEADDEADDEAD,
              64'h2000, 8'h0C, 64'h00000000ABCD0000, 1, 64'h0);
        do_op("sb",  0, 1, 3'b000, 4'b0001, 64'h2005, 64'hFFFFFFFFFFFFFF5A, 64'h0,
              64'h2000, 8'h20, 64'hFFFF5A0000000000, 1, 64'h0);
        do_op("sw",  0, 1, 3'b000, 4'b0100, 64'h200C, 64'h0123456789ABCDEF, 64'h0,
              64'h2008, 8'hF0, 64'h89ABCDEF00000000, 1, 64'h0);
        do_op("sd",  0, 1, 3'b000, 4'b1000, 64'h2008, 64'h0123456789ABCDEF, 64'h0,
              64'h2008, 8'hFF, 64'h0123456789ABCDEF, 1, 64'h0);

`ifdef LSU_MISALIGN_CHK_EN
        present(1'b1, 1'b0, 3'b010, 4'b0000, 64'h3002, 64'h0);
        check("mis_no_req", mem_req_valid, 0);
        check("mis_wb_valid", wb_valid, 1);
        check("mis_flag", misalign, 1);
        check("mis_wb_data", wb_data, 0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("mis_idle", ex_ready, 1);
        present(1'b0, 1'b1, 3'b000, 4'b0100, 64'h2006, 64'h0);
        check("mis_st_no_req", mem_req_valid, 0);
        check("mis_st_flag", misalign, 1);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
`else
        do_op("lw_mis", 1, 0, 3'b010, 4'b0000, 64'h3002, 64'h0, 64'h8877665544332211,
              64'h3000, 8'h00, 64'h0, 0, 64'h0000000066554433);
        do_op("sw_mis", 0, 1, 3'b000, 4'b0100, 64'h2006, 64'h00000000AABBCCDD, 64'h0,
              64'h2000, 8'hC0, 64'hCCDD000000000000, 1, 64'h0);
`endif

        // Back-pressure on every handshake: outputs must hold steady.
        present(1'b1, 1'b0, 3'b001, 4'b0000, 64'h4002, 64'h0);
        for (int i = 0; i < 4; i++) begin
            check("bp_req_valid", mem_req_valid, 1);
            check("bp_req_addr", mem_req_addr, 64'h4000);
            check("bp_stall", stall, 1);
            tick();
        end
        mem_req_ready = 1'b1;
        check("bp_req_last", mem_req_valid, 1);
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_resp_wait", wb_valid, 0);
            check("bp_resp_stall", stall, 1);
            tick();
        end
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'h0000000012345678;
        tick();
        mem_resp_valid = 1'b0; mem_resp_rdata = 64'hFFFFFFFFFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            check("bp_wb_valid", wb_valid, 1);
            check("bp_wb_data", wb_data, 64'h1234);
            check("bp_wb_stall", stall, 1);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        check("bp_done_stall", stall, 0);

        // Reset while waiting in RESP drops the op; a late response is ignored.
        mem_req_ready = 1'b1;
        present(1'b1, 1'b0, 3'b011, 4'b0000, 64'h5000, 64'h0);
        tick();
        mem_req_ready = 1'b0;
        check("rr_in_resp", stall, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rr_ready", ex_ready, 1);
        check("rr_req_valid", mem_req_valid, 0);
        check("rr_wb_valid", wb_valid, 0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hCAFEF00DCAFEF00D;
        tick();
        mem_resp_valid = 1'b0;
        check("rr_late_wb", wb_valid, 0);
        check("rr_late_data", wb_data, 0);
        check("rr_late_ready", ex_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
